// File: rtl/booth_mul_seq_if.sv
// Handshake and adder-side bus of the sequential Booth multiplier.
// slave is the multiplier; master is whoever drives start and owns the ripple adder.
interface booth_mul_seq_if;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_ci;
  logic        add_en;
  logic [7:0]  add_o;

  modport slave (
    input  start, mcand, mplier, add_o,
    output busy, done, product, add_x, add_y, add_ci, add_en
  );

  modport master (
    output start, mcand, mplier, add_o,
    input  busy, done, product, add_x, add_y, add_ci, add_en
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential 8x8 signed radix-2 Booth multiplier. It drives an external 8-bit
// ripple adder during ADD cycles and shifts {a_sgn, A, Q, q_m1} in SHIFT cycles.
// Result after 8 ADD/SHIFT pairs: 17 cycles from the sampled start to done.
module booth_mul_seq (
  input  logic clk,
  input  logic rst,
  booth_mul_seq_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADD   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  a, q, m;
  logic        q_m1, a_sgn;
  logic [2:0]  cnt;
  logic [15:0] product;

  logic [7:0]  add_x, add_y;
  logic        add_ci, add_en;
  logic        ovf;

  // Booth decode of {Q[0], q_m1}: 01 adds M, 10 adds ~M+1, others idle the adder
  always_comb begin
    add_x  = 8'd0;
    add_y  = 8'd0;
    add_ci = 1'b0;
    add_en = 1'b0;
    if (state == ADD) begin
      unique case ({q[0], q_m1})
        2'b01: begin add_x = a; add_y = m;  add_ci = 1'b0; add_en = 1'b1; end
        2'b10: begin add_x = a; add_y = ~m; add_ci = 1'b1; add_en = 1'b1; end
        default: ;
      endcase
    end
  end

  // Signed overflow of the 8-bit add; flips the sum's sign bit into the true sign
  // (needed when M=-128, where subtracting yields +128)
  assign ovf = (add_x[7] == add_y[7]) && (bus.add_o[7] != add_x[7]);

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= 8'd0;
      q       <= 8'd0;
      m       <= 8'd0;
      q_m1    <= 1'b0;
      a_sgn   <= 1'b0;
      cnt     <= 3'd0;
      product <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a     <= 8'd0;
            q     <= bus.mplier;
            m     <= bus.mcand;
            q_m1  <= 1'b0;
            cnt   <= 3'd0;
            state <= ADD;
          end
        end
        ADD: begin
          if (add_en) begin
            a     <= bus.add_o;
            a_sgn <= bus.add_o[7] ^ ovf;
          end else begin
            a_sgn <= a[7];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a    <= {a_sgn, a[7:1]};
          q    <= {a[0], q[7:1]};
          q_m1 <= q[0];
          if (cnt == 3'd7) begin
            product <= {a_sgn, a, q[7:1]};
            state   <= DONE;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= ADD;
          end
        end
        default: state <= IDLE;  // DONE: single-cycle pulse, start ignored
      endcase
    end
  end

  assign bus.busy    = (state == ADD) || (state == SHIFT);
  assign bus.done    = (state == DONE);
  assign bus.product = product;
  assign bus.add_x   = add_x;
  assign bus.add_y   = add_y;
  assign bus.add_ci  = add_ci;
  assign bus.add_en  = add_en;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq; models the external 8-bit ripple adder.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int         done_at, busy_cnt, stray;
  logic [7:0] en_mask, ci_mask;
  int         done_seen;

  booth_mul_seq_if bus();

  booth_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.add_o = bus.add_x + bus.add_y + {7'd0, bus.add_ci};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE. Returns at the negedge of the done cycle (or
  // after a 40-cycle bound). Operands switch to mc2/mp2 at cycle 5.
  task automatic go(input logic [7:0] mc, input logic [7:0] mp, input bit hold,
                    input logic [7:0] mc2, input logic [7:0] mp2);
    bus.mcand  = mc;
    bus.mplier = mp;
    bus.start  = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    done_at = 0; busy_cnt = 0; stray = 0; en_mask = 8'd0; ci_mask = 8'd0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin bus.mcand = mc2; bus.mplier = mp2; end
      if (bus.busy) busy_cnt++;
      if (bus.add_en) begin
        if ((k % 2 == 1) && k <= 15) begin
          en_mask[(k-1)/2] = 1'b1;
          ci_mask[(k-1)/2] = bus.add_ci;
        end else begin
          stray++;
        end
      end
      if (bus.done) begin done_at = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                     input logic [15:0] exp);
    go(mc, mp, 1'b0, mc, mp);
    chk({tag, "_lat"}, done_at, 17);
    chk({tag, "_prod"}, bus.product, exp);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.mcand = 8'd0; bus.mplier = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_prod", bus.product, 16'h0000);
    chk("rst_add", {bus.add_x, bus.add_y, bus.add_ci, bus.add_en}, 0);

    // 3 x 5 with full timing checks
    go(8'd3, 8'd5, 1'b0, 8'd3, 8'd5);
    chk("p35_lat", done_at, 17);
    chk("p35_busy", busy_cnt, 16);
    chk("p35_prod", bus.product, 16'h000F);
    chk("p35_stray", stray, 0);
    @(negedge clk);
    chk("p35_idle_done", bus.done, 0);
    chk("p35_hold_prod", bus.product, 16'h000F);

    run("m3x5",  8'hFD, 8'd5,  16'hFFF1);
    run("5xm3",  8'd5,  8'hFD, 16'hFFF1);
    run("m128sq", 8'h80, 8'h80, 16'h4000);
    run("127xm128", 8'h7F, 8'h80, 16'hC080);
    run("m128x127", 8'h80, 8'h7F, 16'hC080);
    run("m128x1",  8'h80, 8'h01, 16'hFF80);
    run("m1xm1",   8'hFF, 8'hFF, 16'h0001);

    // zero multiplier: adder never enabled
    go(8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00);
    chk("z_prod", bus.product, 16'h0000);
    chk("z_en", en_mask, 8'h00);
    chk("z_stray", stray, 0);
    @(negedge clk);

    // 0x55: every ADD cycle uses the adder, subtract/add alternating
    go(8'd3, 8'h55, 1'b0, 8'd3, 8'h55);
    chk("x55_prod", bus.product, 16'h00FF);
    chk("x55_en", en_mask, 8'hFF);
    chk("x55_ci", ci_mask, 8'h55);
    @(negedge clk);

    // start held throughout, operands changed mid-run
    go(8'd3, 8'd5, 1'b1, 8'h7F, 8'h02);
    chk("hold_lat", done_at, 17);
    chk("hold_prod", bus.product, 16'h000F);
    @(negedge clk);
    chk("hold_idle", {bus.busy, bus.done}, 2'b00);
    go(8'h7F, 8'h02, 1'b0, 8'h7F, 8'h02);
    chk("b2b_lat", done_at, 17);
    chk("b2b_prod", bus.product, 16'h00FE);
    @(negedge clk);

    // reset mid-operation at cycle 8
    bus.mcand = 8'hFD; bus.mplier = 8'h07; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_prod", bus.product, 16'h0000);
    chk("mid_add", {bus.add_x, bus.add_y, bus.add_ci, bus.add_en}, 0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("mid_quiet", done_seen, 0);
    run("post_rst", 8'hFD, 8'd5, 16'hFFF1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
